// File: rtl/bcd_hex_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_hex_counter_display
//
// Parametrised up/down digit counter with a multiplexed seven-segment driver.
// A free-running prescaler generates a one-cycle count tick every TICK_DIV
// clocks. The counter holds NDIG digits in base 16 or base 10 (MODE_BCD). It
// steps on an enabled tick and wraps at either end, pulsing tc on the wrap.
// A separate scan divider walks through the digits every SCAN_DIV clocks
// and drives registered active-low anode/cathode outputs. Leading zeros can
// optionally be blanked.
//
// Parameters
//   NDIG      number of digits (1..8)
//   MODE_BCD  0 = hex digits, 1 = decimal digits
//   TICK_DIV  clk cycles per count tick (>= 1)
//   SCAN_DIV  clk cycles per display digit slot (>= 1)
//   BLANK_LZ  1 = blank leading zero digits (digit 0 is always shown)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   count enable, sampled on tick
//   up_dn     in   1 = count up, 0 = count down, sampled on tick
//   load      in   synchronous load strobe (wins over a coincident tick)
//   load_val  in   load value, one nibble per digit, digit 0 in the LSBs
//   count     out  current counter value
//   tc        out  registered one-cycle wrap pulse
//   an        out  anode enables, active-low
//   seg       out  {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_hex_counter_display #(
    parameter int NDIG     = 4,
    parameter int MODE_BCD = 0,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] count,
    output logic              tc,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
    localparam logic [3:0]    DMAX      = (MODE_BCD != 0) ? 4'd9 : 4'd15;

    // Active-low glyph for one digit value, bits {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]     pre_q,   pre_d;
    logic [SW-1:0]     scan_q,  scan_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [4*NDIG-1:0] count_q, count_d;
    logic              tc_q,    tc_d;
    logic [NDIG-1:0]   an_q,    an_d;
    logic [7:0]        seg_q,   seg_d;

    logic              tick;
    logic              scan_adv;

    // ------------------------------------------------------------------
    // Prescaler and scan divider, both free running
    // ------------------------------------------------------------------
    always_comb begin
        tick     = (pre_q == PRE_LAST);
        pre_d    = tick ? '0 : pre_q + 1'b1;

        scan_adv = (scan_q == SCAN_LAST);
        scan_d   = scan_adv ? '0 : scan_q + 1'b1;
        idx_d    = idx_q;
        if (scan_adv) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counter: ripple carry/borrow through all digits in one cycle.
    // The carry that falls out of the top digit is the wrap indication.
    // ------------------------------------------------------------------
    logic [4*NDIG-1:0] cnt_step;
    logic [4*NDIG-1:0] ld_clamp;
    logic [3:0]        dig;
    logic [3:0]        ld_dig;
    logic              carry;

    always_comb begin
        cnt_step = count_q;
        carry    = 1'b1;
        dig      = '0;
        for (int i = 0; i < NDIG; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (dig == DMAX) begin
                        dig = '0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = DMAX;
                    end else begin
                        dig   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            cnt_step[4*i +: 4] = dig;
        end
    end

    // Decimal mode never lets a non-decimal nibble into the counter
    always_comb begin
        ld_clamp = load_val;
        ld_dig   = '0;
        for (int i = 0; i < NDIG; i++) begin
            ld_dig = load_val[4*i +: 4];
            if ((MODE_BCD != 0) && (ld_dig > 4'd9)) begin
                ld_clamp[4*i +: 4] = 4'd9;
            end
        end
    end

    // Load has priority; a tick coinciding with load is dropped
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = ld_clamp;
        end else if (tick && en) begin
            count_d = cnt_step;
            tc_d    = carry;
        end
    end

    // ------------------------------------------------------------------
    // Display: pick the scanned digit and build registered an/seg
    // ------------------------------------------------------------------
    logic [NDIG-1:0] blank_vec;
    logic            hi_zero;
    logic [3:0]      cur_dig;
    logic            cur_blank;

    // A digit is a leading zero when it and everything above it is zero
    always_comb begin
        blank_vec = '0;
        hi_zero   = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            hi_zero      = hi_zero && (count_q[4*i +: 4] == 4'd0);
            blank_vec[i] = (BLANK_LZ != 0) && (i > 0) && hi_zero;
        end
    end

    always_comb begin
        cur_dig   = '0;
        cur_blank = 1'b0;
        an_d      = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                cur_dig   = count_q[4*i +: 4];
                cur_blank = blank_vec[i];
                an_d[i]   = 1'b0;
            end
        end
        seg_d = cur_blank ? 8'hFF : {1'b1, glyph(cur_dig)};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
        end else begin
            pre_q   <= pre_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule
